// File: rtl/avg_controller.sv
// Sequencing FSM for the sample-averaging datapath: load, 4-sample windowed sum, history shift.
// Also generates a single clear/batch_done pulse on the rising edge of one_k_samples.
//
// state | meaning
// IDLE  | waiting for data_ready
// STORE | load new sample into R1, bump sample counter
// SUM1  | R0 <= R1 + R2
// SUM2  | R0 <= R0 + R3
// SUM3  | R0 <= R0 + R4
// SH4   | R4 <= R3
// SH3   | R3 <= R2
// SH2   | R2 <= R1
// EIDLE | overflow seen, err held until next sample
module avg_controller #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              data_ready,
  input  logic              overflow,
  input  logic              one_k_samples,
  output logic              cnt_up,
  output logic              clear,
  output logic              batch_done,
  output logic              modwait,
  output logic              err,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest
);

  typedef enum logic [3:0] {
    IDLE, STORE, SUM1, SUM2, SUM3, SH4, SH3, SH2, EIDLE
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_COPY = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;

  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] R1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] R2 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] R3 = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] R4 = ADDR_W'(4);

  state_t state, next;

  logic              d_cnt_up, d_modwait, d_err;
  logic [2:0]        d_op;
  logic [ADDR_W-1:0] d_src1, d_src2, d_dest;

  logic one_k_q;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (data_ready) next = STORE;
      STORE:   next = SUM1;
      SUM1:    next = overflow ? EIDLE : SUM2;
      SUM2:    next = overflow ? EIDLE : SUM3;
      SUM3:    next = overflow ? EIDLE : SH4;
      SH4:     next = SH3;
      SH3:     next = SH2;
      SH2:     next = IDLE;
      EIDLE:   if (data_ready) next = STORE;
      default: next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state.
  always_comb begin
    d_op      = OP_NOP;
    d_src1    = R0;
    d_src2    = R0;
    d_dest    = R0;
    d_cnt_up  = 1'b0;
    d_modwait = 1'b1;
    d_err     = 1'b0;
    case (next)
      IDLE:  d_modwait = 1'b0;
      STORE: begin d_op = OP_LOAD; d_dest = R1; d_cnt_up = 1'b1; end
      SUM1:  begin d_op = OP_ADD;  d_src1 = R1; d_src2 = R2; end
      SUM2:  begin d_op = OP_ADD;  d_src2 = R3; end
      SUM3:  begin d_op = OP_ADD;  d_src2 = R4; end
      SH4:   begin d_op = OP_COPY; d_src1 = R3; d_dest = R4; end
      SH3:   begin d_op = OP_COPY; d_src1 = R2; d_dest = R3; end
      SH2:   begin d_op = OP_COPY; d_src1 = R1; d_dest = R2; end
      EIDLE: begin d_modwait = 1'b0; d_err = 1'b1; end
      default: d_modwait = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      op      <= OP_NOP;
      src1    <= R0;
      src2    <= R0;
      dest    <= R0;
      cnt_up  <= 1'b0;
      modwait <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= next;
      op      <= d_op;
      src1    <= d_src1;
      src2    <= d_src2;
      dest    <= d_dest;
      cnt_up  <= d_cnt_up;
      modwait <= d_modwait;
      err     <= d_err;
    end
  end

  // Edge detect on the sticky flag; independent of the sequencing FSM.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      one_k_q    <= 1'b0;
      clear      <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      one_k_q    <= one_k_samples;
      clear      <= one_k_samples & ~one_k_q;
      batch_done <= one_k_samples & ~one_k_q;
    end
  end

endmodule

// File: tb/tb_avg_controller.sv
// Bench for avg_controller: sequence-position model plus directed literal checks.
module tb_avg_controller;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       data_ready = 1'b0;
  logic       overflow = 1'b0;
  logic       one_k_samples = 1'b0;
  logic       cnt_up, clear, batch_done, modwait, err;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;

  avg_controller #(.ADDR_W(4)) dut (
    .clk(clk), .n_reset(n_reset), .data_ready(data_ready), .overflow(overflow),
    .one_k_samples(one_k_samples), .cnt_up(cnt_up), .clear(clear),
    .batch_done(batch_done), .modwait(modwait), .err(err), .op(op),
    .src1(src1), .src2(src2), .dest(dest)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs per position in the 7-cycle sample sequence (0 = idle).
  int op_t  [8] = '{0, 2, 3, 3, 3, 1, 1, 1};
  int s1_t  [8] = '{0, 0, 1, 0, 0, 3, 2, 1};
  int s2_t  [8] = '{0, 0, 2, 3, 4, 0, 0, 0};
  int dst_t [8] = '{0, 1, 0, 0, 0, 4, 3, 2};

  int   m_step;
  logic m_err, m_flag_prev, m_pulse;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_step = 0; m_err = 1'b0; m_flag_prev = 1'b0; m_pulse = 1'b0;
    end else begin
      if (m_step == 0) begin
        if (data_ready) begin m_step = 1; m_err = 1'b0; end
      end else if (m_step >= 2 && m_step <= 4 && overflow) begin
        m_step = 0; m_err = 1'b1;
      end else if (m_step == 7) m_step = 0;
      else m_step = m_step + 1;
      m_pulse     = one_k_samples & ~m_flag_prev;
      m_flag_prev = one_k_samples;
    end
  end

  // Sample counter environment: counts cnt_up, cleared by clear, flag sticky at 1000.
  int   k_count;
  logic k_flag;
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      k_count = 0; k_flag = 1'b0; one_k_samples = 1'b0;
    end else begin
      if (clear) k_count = 0;
      else if (cnt_up) k_count++;
      if (k_count >= 1000) k_flag = 1'b1;
      #1 one_k_samples = k_flag;
    end
  end

  logic [19:0] act_vec, exp_vec;
  assign act_vec = {op, src1, src2, dest, cnt_up, modwait, err, clear, batch_done};
  always_comb begin
    exp_vec = {op_t[m_step][2:0], s1_t[m_step][3:0], s2_t[m_step][3:0], dst_t[m_step][3:0],
               m_step == 1, m_step != 0, m_err && m_step == 0, m_pulse, m_pulse};
  end

  int cyc = 0, bd_count = 0, rise_cyc = -1, bd_cyc = -1;
  always @(negedge clk) begin
    cyc++;
    chk("outputs", 32'(act_vec), 32'(exp_vec));
    if (batch_done) begin bd_count++; if (bd_cyc < 0) bd_cyc = cyc; end
    if (one_k_samples && rise_cyc < 0) rise_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    n_reset = 1'b0; data_ready = 1'b0; overflow = 1'b0;
    tick(); tick();
    n_reset = 1'b1;
  endtask

  initial begin
    // Reset and idle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk);
      chk("idle_vec", {op, cnt_up, clear, modwait, err}, 0);
    end

    // Full sequence with literal expectations, plus an ignored mid-sequence pulse.
    tick(); data_ready = 1'b1; tick(); data_ready = 1'b0;
    @(negedge clk);
    chk("store_op", op, 3'b010); chk("store_dest", dest, 1); chk("store_cnt", cnt_up, 1);
    chk("store_mw", modwait, 1);
    tick(); @(negedge clk); chk("sum1_src", {src1, src2}, 8'h12); chk("sum1_op", op, 3);
    data_ready = 1'b1;
    tick(); data_ready = 1'b0;
    @(negedge clk); chk("sum2_src", {src1, src2}, 8'h03); chk("ign_cnt", cnt_up, 0);
    tick(); @(negedge clk); chk("sum3_src", {src1, src2}, 8'h04);
    tick(); @(negedge clk); chk("sh4", {op, src1, dest}, {3'd1, 4'd3, 4'd4});
    tick(); @(negedge clk); chk("sh3", {op, src1, dest}, {3'd1, 4'd2, 4'd3});
    tick(); @(negedge clk); chk("sh2", {op, src1, dest}, {3'd1, 4'd1, 4'd2});
    chk("sh2_mw", modwait, 1);
    tick(); @(negedge clk); chk("back_idle", {op, modwait}, 0);

    // Overflow during SUM2 -> EIDLE with err held, cleared by next sample.
    tick(); data_ready = 1'b1; tick(); data_ready = 1'b0;
    tick(); tick(); overflow = 1'b1; tick(); overflow = 1'b0;
    @(negedge clk); chk("ov_err", {err, modwait, op}, {1'b1, 1'b0, 3'd0});
    tick(); tick(); tick(); @(negedge clk); chk("ov_hold", err, 1);
    data_ready = 1'b1; tick(); data_ready = 1'b0;
    @(negedge clk); chk("ov_store", {err, op}, {1'b0, 3'd2});
    for (int i = 0; i < 8; i++) tick();

    // Reset mid-SUM3.
    data_ready = 1'b1; tick(); data_ready = 1'b0;
    tick(); tick(); tick();
    @(negedge clk); chk("pre_rst_sum3", {op, src2}, {3'd3, 4'd4});
    #1 n_reset = 1'b0; #1;
    chk("rst_now", {op, modwait, err, cnt_up}, 0);
    tick(); n_reset = 1'b1;
    tick(); data_ready = 1'b1; tick(); data_ready = 1'b0;
    @(negedge clk); chk("post_rst_store", {op, dest, cnt_up}, {3'd2, 4'd1, 1'b1});
    for (int i = 0; i < 8; i++) tick();

    // Random data_ready / overflow traffic against the model.
    for (int i = 0; i < 600; i++) begin
      data_ready = ($urandom_range(0, 3) == 0);
      overflow   = ($urandom_range(0, 5) == 0);
      tick();
    end
    data_ready = 1'b0; overflow = 1'b0;

    // Batch: 1010 samples at 8-cycle spacing; exactly one pulse, one cycle after flag rise.
    do_reset();
    bd_count = 0; rise_cyc = -1; bd_cyc = -1;
    for (int s = 0; s < 1010; s++) begin
      data_ready = 1'b1; tick(); data_ready = 1'b0;
      for (int i = 0; i < 7; i++) tick();
    end
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("flag_rose", one_k_samples, 1);
    chk("batch_pulses", bd_count, 1);
    if (rise_cyc < 0) chk("flag_timeout", 0, 1);
    else chk("pulse_delay", bd_cyc - rise_cyc, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
